adc_moving_average: RTL and testbench
=====================================

// Module: adc_moving_average
// PURPOSE
// Sits between the SPI ADC reader and the UART/data path. Consumes each 12-bit
// ADC conversion, keeps a sliding window of the last 2^LOG2_DEPTH samples and
// produces their running mean. A hysteresis comparator on that mean drives the
// digital level (dreading) that feeds the UART receiver input.
// PARAMETERS
// LOG2_DEPTH  3     log2 of window length; DEPTH = 2^LOG2_DEPTH (1..6 legal)
// SAMPLE_W    12    ADC sample width in bits
// PORTS
// int_clk       in   1               system clock; all logic on rising edge
// rst           in   1               synchronous reset, active-high
// sample_in     in   SAMPLE_W        ADC conversion result
// sample_valid  in   1               1-cycle strobe: sample_in is new
// thr_high      in   SAMPLE_W        rising threshold (mean > thr_high -> 1)
// thr_low       in   SAMPLE_W        falling threshold (mean < thr_low -> 0)
// avg_out       out  SAMPLE_W        window mean, floor(sum / DEPTH)
// avg_valid     out  1               1-cycle strobe: avg_out/dreading updated
// dreading      out  1               hysteresis digital level
// filled        out  1               window holds DEPTH samples since reset
// BEHAVIOUR
// - Reset (rst=1 at edge): avg_out=0, avg_valid=0, dreading=0, filled=0,
//   accumulator=0, write pointer=0, fill count=0. Sample RAM not cleared.
// - Storage: DEPTH x SAMPLE_W RAM, circular write pointer wp (LOG2_DEPTH bits,
//   wraps DEPTH-1 -> 0). Oldest sample = mem[wp] (asynchronous read).
// - Accumulator width SAMPLE_W+LOG2_DEPTH; never overflows, unsigned.
// - On edge with sample_valid=1:
//   old = filled ? mem[wp] : 0; acc <= acc + sample_in - old;
//   mem[wp] <= sample_in; wp <= wp+1; count <= count+1 (saturate at DEPTH);
//   filled <= 1 when count reaches DEPTH (i.e. on the DEPTH-th sample).
// - Output stage, same edge, only when the accepted sample completes or keeps
//   a full window (count+1 >= DEPTH): avg_out <= (acc + sample_in - old) >>
//   LOG2_DEPTH; avg_valid <= 1. Otherwise avg_valid <= 0, avg_out holds.
// - Latency: avg_valid pulses exactly 1 cycle after the sample_valid strobe.
// - Back-to-back sample_valid every cycle fully supported, no stalls.
// - Hysteresis, evaluated on the new mean in the cycle avg_valid is set:
//   mean > thr_high -> dreading<=1; else mean < thr_low -> dreading<=0;
//   else hold. Ties (equal) hold. If thr_low > thr_high, high test wins.
//   dreading changes only together with an avg_valid pulse.
// - Thresholds sampled live; changing them affects only the next mean.
// - rst mid-window: all state above reinitialised; refill of DEPTH samples
//   required before next avg_valid; stale RAM never contributes (count gate).
// - rst and sample_valid in same cycle: reset wins, sample discarded.
// - No sample_valid: all outputs hold, avg_valid=0.
// TESTING (LOG2_DEPTH=2, DEPTH=4, SAMPLE_W=12 unless stated)
// 1 Fill: 100,200,300,400 strobed -> no avg_valid for first 3; after 4th,
//   next cycle avg_valid=1, avg_out=250, filled=1.
// 2 Slide/wrap: continue 500,600 -> avg_out=350 then 450; wp wraps cleanly.
// 3 Hysteresis: thr_high=2000, thr_low=1000; 4x2100 -> dreading=1; 4x1500
//   -> stays 1; 4x1000 -> stays 1 (tie); 4x900 -> dreading=0.
// 4 Full-scale: back-to-back 4095 every cycle x8 -> avg_out=4095, one
//   avg_valid per strobe from 4th on, no overflow; then 0 x4 -> avg_out=0.
// 5 Reset mid-fill: 2 samples of 4000, rst 1 cycle, then 10,20,30,40 ->
//   avg_out=25 (stale 4000 excluded), avg_valid only after 4th new sample.
// 6 rst with sample_valid same cycle -> sample dropped, filled=0, count=0.

Source files
------------

// File: rtl/adc_moving_average.sv
`default_nettype none
// ============================================================================
// Module      : adc_moving_average
// Description : Sliding-window mean of ADC samples with a hysteresis level out.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_moving_average #(
    parameter int LOG2_DEPTH = 3,
    parameter int SAMPLE_W   = 12
) (
    input  logic                int_clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] thr_high,
    input  logic [SAMPLE_W-1:0] thr_low,
    output logic [SAMPLE_W-1:0] avg_out,
    output logic                avg_valid,
    output logic                dreading,
    output logic                filled
);

    localparam int c_DEPTH = 1 << LOG2_DEPTH;
    localparam int c_ACC_W = SAMPLE_W + LOG2_DEPTH;
    localparam int c_CNT_W = LOG2_DEPTH + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT   = c_CNT_W'(c_DEPTH);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT    = c_CNT_W'(c_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [LOG2_DEPTH-1:0] c_WP_ONE   = LOG2_DEPTH'(1);

    logic [SAMPLE_W-1:0]   r_mem [c_DEPTH];
    logic [LOG2_DEPTH-1:0] r_wp;
    logic [c_CNT_W-1:0]    r_count;
    logic [c_ACC_W-1:0]    r_acc;
    logic                  r_filled;
    logic [SAMPLE_W-1:0]   r_avg;
    logic                  r_avg_valid;
    logic                  r_dreading;

    logic [SAMPLE_W-1:0]   w_old;
    logic [c_ACC_W-1:0]    w_acc_next;
    logic [SAMPLE_W-1:0]   w_mean;
    logic                  w_window_ready;

    // Until the window is full the slot under wp holds stale data and must not be subtracted.
    assign w_old          = r_filled ? r_mem[r_wp] : '0;
    assign w_acc_next     = r_acc + c_ACC_W'(sample_in) - c_ACC_W'(w_old);
    assign w_mean         = w_acc_next[c_ACC_W-1:LOG2_DEPTH];
    assign w_window_ready = (r_count >= c_LAST_CNT);

    always_ff @(posedge int_clk) begin
        if (sample_valid && !rst) begin
            r_mem[r_wp] <= sample_in;
        end
    end

    always_ff @(posedge int_clk) begin
        if (rst) begin
            r_wp        <= '0;
            r_count     <= '0;
            r_acc       <= '0;
            r_filled    <= 1'b0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_dreading  <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;
            if (sample_valid) begin
                r_acc <= w_acc_next;
                r_wp  <= r_wp + c_WP_ONE;
                if (r_count != c_DEPTH_CNT) begin
                    r_count <= r_count + c_CNT_ONE;
                end
                if (r_count == c_LAST_CNT) begin
                    r_filled <= 1'b1;
                end
                if (w_window_ready) begin
                    r_avg       <= w_mean;
                    r_avg_valid <= 1'b1;
                    // High test takes priority so inverted thresholds resolve to 1.
                    if (w_mean > thr_high) begin
                        r_dreading <= 1'b1;
                    end else if (w_mean < thr_low) begin
                        r_dreading <= 1'b0;
                    end
                end
            end
        end
    end

    assign avg_out   = r_avg;
    assign avg_valid = r_avg_valid;
    assign dreading  = r_dreading;
    assign filled    = r_filled;

endmodule
`default_nettype wire

// File: tb/tb_adc_moving_average.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_moving_average
// Description : Directed and random checks of adc_moving_average (DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_moving_average;

    localparam int LOG2_DEPTH = 2;
    localparam int SAMPLE_W   = 12;
    localparam int DEPTH      = 4;

    logic                int_clk = 1'b0;
    logic                rst;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_in;
    logic [SAMPLE_W-1:0] thr_high;
    logic [SAMPLE_W-1:0] thr_low;
    logic [SAMPLE_W-1:0] avg_out;
    logic                avg_valid;
    logic                dreading;
    logic                filled;

    adc_moving_average #(
        .LOG2_DEPTH (LOG2_DEPTH),
        .SAMPLE_W   (SAMPLE_W)
    ) u_dut (
        .int_clk      (int_clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .thr_high     (thr_high),
        .thr_low      (thr_low),
        .avg_out      (avg_out),
        .avg_valid    (avg_valid),
        .dreading     (dreading),
        .filled       (filled)
    );

    always #5 int_clk = ~int_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: the literal list of samples accepted since the last reset.
    int unsigned win[$];
    int          exp_avg   = 0;
    int          exp_valid = 0;
    int          exp_dread = 0;
    int          exp_fill  = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input int s);
        int unsigned sum;
        int unsigned mean;
        rst          = r;
        sample_valid = v;
        sample_in    = SAMPLE_W'(s);
        @(posedge int_clk);
        if (r) begin
            win.delete();
            exp_avg   = 0;
            exp_valid = 0;
            exp_dread = 0;
            exp_fill  = 0;
        end else if (v) begin
            win.push_back(int'(s) & 32'hFFF);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win.size() == DEPTH) begin
                sum = 0;
                foreach (win[i]) sum += win[i];
                mean      = sum / DEPTH;
                exp_avg   = int'(mean);
                exp_valid = 1;
                exp_fill  = 1;
                if (mean > thr_high)     exp_dread = 1;
                else if (mean < thr_low) exp_dread = 0;
            end else begin
                exp_valid = 0;
            end
        end else begin
            exp_valid = 0;
        end
        #1;
        check_val("avg_valid", int'(avg_valid), exp_valid);
        check_val("avg_out",   int'(avg_out),   exp_avg);
        check_val("dreading",  int'(dreading),  exp_dread);
        check_val("filled",    int'(filled),    exp_fill);
    endtask

    initial begin
        rst          = 1'b1;
        sample_valid = 1'b0;
        sample_in    = '0;
        thr_high     = 12'd4095;
        thr_low      = 12'd0;

        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // Fill then slide through the pointer wrap
        step(0, 1, 100);
        step(0, 1, 200);
        step(0, 1, 300);
        check_val("t1_no_valid_before_4th", int'(avg_valid), 0);
        step(0, 1, 400);
        check_val("t1_avg", int'(avg_out), 250);
        check_val("t1_filled", int'(filled), 1);
        step(0, 1, 500);
        check_val("t2_avg_a", int'(avg_out), 350);
        step(0, 1, 600);
        check_val("t2_avg_b", int'(avg_out), 450);
        step(0, 0, 0);

        // Hysteresis band, including the tie on thr_low
        thr_high = 12'd2000;
        thr_low  = 12'd1000;
        repeat (4) step(0, 1, 2100);
        check_val("t3_high", int'(dreading), 1);
        repeat (4) step(0, 1, 1500);
        check_val("t3_band", int'(dreading), 1);
        repeat (4) step(0, 1, 1000);
        check_val("t3_tie", int'(dreading), 1);
        repeat (4) step(0, 1, 900);
        check_val("t3_low", int'(dreading), 0);

        // Full-scale back-to-back
        step(1, 0, 0);
        repeat (8) step(0, 1, 4095);
        check_val("t4_full", int'(avg_out), 4095);
        repeat (4) step(0, 1, 0);
        check_val("t4_zero", int'(avg_out), 0);

        // Reset mid-fill: stale samples must not leak into the new window
        step(0, 1, 4000);
        step(0, 1, 4000);
        step(1, 0, 0);
        step(0, 1, 10);
        step(0, 1, 20);
        step(0, 1, 30);
        step(0, 1, 40);
        check_val("t5_avg", int'(avg_out), 25);

        // Reset wins over a coincident strobe
        step(1, 1, 777);
        check_val("t6_filled", int'(filled), 0);
        step(0, 1, 1);
        step(0, 1, 2);
        step(0, 1, 3);
        check_val("t6_still_filling", int'(avg_valid), 0);
        step(0, 1, 6);
        check_val("t6_avg", int'(avg_out), 3);

        // Random traffic, occasional resets, live threshold changes
        for (int n = 0; n < 400; n++) begin
            int s;
            if ($urandom_range(0, 29) == 0) begin
                thr_high = SAMPLE_W'($urandom_range(0, 4095));
                thr_low  = SAMPLE_W'($urandom_range(0, 4095));
            end
            case ($urandom_range(0, 3))
                0:       s = 0;
                1:       s = 4095;
                default: s = int'($urandom_range(0, 4095));
            endcase
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
